// File: rtl/led_seq_fsm.sv
// rtl/led_seq_fsm.sv - parametrised N-LED sequencer with off / chase-left / chase-right / bounce modes
//
// Ports:
//   clk    in   1   system clock, rising edge
//   rst_n  in   1   synchronous reset, active low
//   inp    in   4   one-hot mode request: 0001 OFF, 0010 LEFT, 0100 RIGHT, 1000 BOUNCE
//   hold   in   1   freezes prescaler, pattern and bounce direction
//   out    out  N   registered LED drive
//   mode   out  2   current mode: 0 OFF, 1 LEFT, 2 RIGHT, 3 BOUNCE
//   tick   out  1   registered pulse in the cycle out changes due to a step

module led_seq_fsm #(
  parameter int N     = 8,
  parameter int CYCLE = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [3:0]   inp,
  input  logic         hold,
  output logic [N-1:0] out,
  output logic [1:0]   mode,
  output logic         tick
);

  localparam int CW = (CYCLE > 1) ? $clog2(CYCLE) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CYCLE - 1);

  typedef enum logic [1:0] {
    S_OFF    = 2'd0,
    S_LEFT   = 2'd1,
    S_RIGHT  = 2'd2,
    S_BOUNCE = 2'd3
  } state_t;

  state_t         state, state_nxt;
  state_t         req_mode;
  logic           req_valid;
  logic [CW-1:0]  cnt, cnt_nxt;
  logic [N-1:0]   out_nxt;
  logic           dir_down, dir_down_nxt;
  logic           tick_nxt;

  // Pattern loaded on entry to each mode.
  function automatic logic [N-1:0] seed_of(input state_t s);
    logic [N-1:0] v;
    v = '0;
    case (s)
      S_LEFT, S_BOUNCE: v[0]   = 1'b1;
      S_RIGHT:          v[N-1] = 1'b1;
      default:          v      = '0;
    endcase
    return v;
  endfunction

  // Only exactly-one-hot requests are honoured; everything else is ignored.
  always_comb begin
    req_valid = 1'b1;
    req_mode  = S_OFF;
    case (inp)
      4'b0001: req_mode  = S_OFF;
      4'b0010: req_mode  = S_LEFT;
      4'b0100: req_mode  = S_RIGHT;
      4'b1000: req_mode  = S_BOUNCE;
      default: req_valid = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= S_OFF;
      cnt      <= '0;
      out      <= '0;
      dir_down <= 1'b0;
      tick     <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      out      <= out_nxt;
      dir_down <= dir_down_nxt;
      tick     <= tick_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    out_nxt      = out;
    dir_down_nxt = dir_down;
    tick_nxt     = 1'b0;

    if (req_valid && (req_mode != state)) begin
      // A mode change wins over hold and over a step due on this edge.
      state_nxt    = req_mode;
      cnt_nxt      = '0;
      out_nxt      = seed_of(req_mode);
      dir_down_nxt = 1'b0;
    end else if ((state != S_OFF) && !hold) begin
      if (cnt == CNT_LAST) begin
        cnt_nxt  = '0;
        tick_nxt = 1'b1;
        case (state)
          S_LEFT:  out_nxt = {out[N-2:0], out[N-1]};
          S_RIGHT: out_nxt = {out[0], out[N-1:1]};
          S_BOUNCE: begin
            // Direction flips on the step that lands on an end LED, so each
            // end is lit for exactly one step.
            if (!dir_down) begin
              out_nxt = {out[N-2:0], 1'b0};
              if (out_nxt[N-1]) dir_down_nxt = 1'b1;
            end else begin
              out_nxt = {1'b0, out[N-1:1]};
              if (out_nxt[0]) dir_down_nxt = 1'b0;
            end
          end
          default: out_nxt = '0;
        endcase
      end else begin
        cnt_nxt = cnt + CW'(1);
      end
    end
  end

  assign mode = state;

endmodule

// File: tb/tb_led_seq_fsm.sv
// tb/tb_led_seq_fsm.sv - self-checking bench for led_seq_fsm against a step-count reference model

module tb_led_seq_fsm;

  localparam int N     = 4;
  localparam int CYCLE = 5;

  logic         clk;
  logic         rst_n;
  logic [3:0]   inp;
  logic         hold;
  logic [N-1:0] out;
  logic [1:0]   mode;
  logic         tick;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: mode, running clocks since the seed, last tick.
  int m_mode = 0;
  int m_run  = 0;
  bit m_tick = 0;

  led_seq_fsm #(.N(N), .CYCLE(CYCLE)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .inp  (inp),
    .hold (hold),
    .out  (out),
    .mode (mode),
    .tick (tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pattern as a function of how many steps have elapsed since the seed.
  function automatic logic [N-1:0] model_out();
    int k, j, pos;
    logic [N-1:0] v;
    v = '0;
    k = m_run / CYCLE;
    case (m_mode)
      1: v[k % N] = 1'b1;
      2: v[N - 1 - (k % N)] = 1'b1;
      3: begin
        j   = k % (2 * N - 2);
        pos = (j < N) ? j : (2 * N - 2 - j);
        v[pos] = 1'b1;
      end
      default: v = '0;
    endcase
    return v;
  endfunction

  function automatic bit model_dir_down();
    int j;
    j = (m_run / CYCLE) % (2 * N - 2);
    return (m_mode == 3) && (j >= N - 1);
  endfunction

  task automatic model_edge();
    int req;
    bit valid;
    valid = ($countones(inp) == 1);
    req   = inp[0] ? 0 : inp[1] ? 1 : inp[2] ? 2 : 3;
    if (!rst_n) begin
      m_mode = 0; m_run = 0; m_tick = 0;
    end else if (valid && req != m_mode) begin
      m_mode = req; m_run = 0; m_tick = 0;
    end else if (m_mode != 0 && !hold) begin
      m_run  = m_run + 1;
      m_tick = (m_run % CYCLE) == 0;
    end else begin
      m_tick = 0;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic cyc(input logic [3:0] i, input logic h, input logic r);
    inp = i; hold = h; rst_n = r;
    @(posedge clk);
    model_edge();
    #1;
    chk("out",  32'(out),  32'(model_out()));
    chk("mode", 32'(mode), 32'(m_mode));
    chk("tick", 32'(tick), 32'(m_tick));
  endtask

  logic [3:0] ri;

  initial begin
    inp = 4'b0001; hold = 1'b0; rst_n = 1'b0;

    // Reset state.
    cyc(4'b0001, 1'b0, 1'b0);
    cyc(4'b0001, 1'b0, 1'b0);
    chk("reset_out", 32'(out), 32'h0);
    chk("reset_mode", 32'(mode), 32'h0);

    // LEFT: seed one clock after the request, then steps every CYCLE clocks.
    cyc(4'b0010, 1'b0, 1'b1);
    chk("left_seed", 32'(out), 32'h1);
    for (int c = 0; c < 4 * CYCLE; c++) cyc(4'b0010, 1'b0, 1'b1);
    chk("left_wrap", 32'(out), 32'h1);

    // Switch to RIGHT when the prescaler is at 3.
    for (int c = 0; c < 20 && (m_run % CYCLE) != 3; c++) cyc(4'b0010, 1'b0, 1'b1);
    chk("left_cnt3", 32'(m_run % CYCLE), 32'd3);
    cyc(4'b0100, 1'b0, 1'b1);
    chk("right_seed", 32'(out), 32'h8);
    for (int c = 0; c < 4 * CYCLE + 2; c++) cyc(4'b0100, 1'b0, 1'b1);

    // BOUNCE over more than one period.
    for (int c = 0; c < 8 * CYCLE + 1; c++) cyc(4'b1000, 1'b0, 1'b1);

    // Hold during LEFT at out=0100, cnt=2 for 12 clocks.
    cyc(4'b0010, 1'b0, 1'b1);
    for (int c = 0; c < 40 && !(out == 4'b0100 && (m_run % CYCLE) == 2); c++)
      cyc(4'b0010, 1'b0, 1'b1);
    for (int c = 0; c < 12; c++) cyc(4'b0010, 1'b1, 1'b1);
    chk("hold_out", 32'(out), 32'h4);
    cyc(4'b0010, 1'b0, 1'b1);
    cyc(4'b0010, 1'b0, 1'b1);
    chk("hold_no_tick_yet", 32'(tick), 32'h0);
    cyc(4'b0010, 1'b0, 1'b1);
    chk("hold_release_tick", 32'(tick), 32'h1);

    // Invalid and repeated requests during RIGHT.
    cyc(4'b0100, 1'b0, 1'b1);
    for (int c = 0; c < 7; c++) cyc(4'b0000, 1'b0, 1'b1);
    for (int c = 0; c < 7; c++) cyc(4'b0110, 1'b0, 1'b1);
    for (int c = 0; c < 7; c++) cyc(4'b0100, 1'b0, 1'b1);
    chk("right_mode_kept", 32'(mode), 32'd2);

    // Reset mid-BOUNCE while heading down, request still BOUNCE.
    cyc(4'b1000, 1'b0, 1'b1);
    for (int c = 0; c < 60 && !model_dir_down(); c++) cyc(4'b1000, 1'b0, 1'b1);
    cyc(4'b1000, 1'b0, 1'b0);
    chk("rst_out", 32'(out), 32'h0);
    chk("rst_mode", 32'(mode), 32'h0);
    cyc(4'b1000, 1'b0, 1'b1);
    chk("bounce_restart", 32'(out), 32'h1);
    for (int c = 0; c < 3 * CYCLE; c++) cyc(4'b1000, 1'b0, 1'b1);

    // Randomised traffic: sticky requests, invalid codes, hold bursts, rare reset.
    ri = 4'b0010;
    for (int c = 0; c < 3000; c++) begin
      case ($urandom_range(0, 19))
        0:       ri = 4'b0001;
        1:       ri = 4'b0010;
        2:       ri = 4'b0100;
        3:       ri = 4'b1000;
        4:       ri = 4'($urandom_range(0, 15));
        default: ri = ri;
      endcase
      cyc(ri, ($urandom_range(0, 5) == 0), ($urandom_range(0, 199) != 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
